// File: rtl/uart_tx_sched.sv
// Two-requester round-robin scheduler feeding an 8N1 UART transmitter.
// The line is only opened to a new byte while idle and the synchronized CTS is low.
module uart_tx_sched #(
    parameter int unsigned ClksPerBit = 868
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_req0_data,
    input  logic       i_req0_valid,
    output logic       o_req0_ready,
    input  logic [7:0] i_req1_data,
    input  logic       i_req1_valid,
    output logic       o_req1_ready,
    output logic       o_uart_tx,
    input  logic       i_uart_cts_n,
    output logic       o_busy,
    output logic       o_grant
);

    localparam int unsigned CntW = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(ClksPerBit - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          r_state;
    logic [CntW-1:0] r_baud;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic            r_cts_meta;
    logic            r_cts_sync;
    logic            r_tx;
    logic            r_busy;
    logic            r_grant;

    logic w_open;
    logic w_any;
    logic w_pick;
    logic w_accept;
    logic w_bit_end;

    // Round-robin pick: a lone requester wins, on contention the one not last granted wins.
    assign w_open    = (r_state == IDLE) && !r_cts_sync;
    assign w_any     = i_req0_valid || i_req1_valid;
    assign w_pick    = (i_req0_valid && i_req1_valid) ? !r_grant : !i_req0_valid;
    assign w_accept  = w_open && w_any;
    assign w_bit_end = (r_baud == CntMax);

    assign o_req0_ready = w_accept && !w_pick;
    assign o_req1_ready = w_accept && w_pick;
    assign o_uart_tx    = r_tx;
    assign o_busy       = r_busy;
    assign o_grant      = r_grant;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cts_meta <= 1'b1;
            r_cts_sync <= 1'b1;
        end else begin
            r_cts_meta <= i_uart_cts_n;
            r_cts_sync <= r_cts_meta;
        end
    end

    // Frame sequencer; the line level for each bit is registered on the bit boundary.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_grant <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_baud <= '0;
                    r_bit  <= '0;
                    if (w_accept) begin
                        r_shift <= w_pick ? i_req1_data : i_req0_data;
                        r_grant <= w_pick;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= DATA;
                    end else begin
                        r_baud <= r_baud + CntW'(1);
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        r_bit  <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_tx    <= r_shift[1];
                            r_shift <= {1'b0, r_shift[7:1]};
                        end
                    end else begin
                        r_baud <= r_baud + CntW'(1);
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_baud <= r_baud + CntW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: arbitration vector table, frame-decoding monitor
// against an expected-byte queue, and directed CTS / reset corner sequences.
module tb_uart_tx_sched;

    localparam int CPB = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] d0 = 8'h00;
    logic [7:0] d1 = 8'h00;
    logic       v0 = 1'b0;
    logic       v1 = 1'b0;
    logic       r0;
    logic       r1;
    logic       tx;
    logic       cts = 1'b1;
    logic       busy;
    logic       grant;

    uart_tx_sched #(.ClksPerBit(CPB)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req0_data  (d0),
        .i_req0_valid (v0),
        .o_req0_ready (r0),
        .i_req1_data  (d1),
        .i_req1_valid (v1),
        .o_req1_ready (r1),
        .o_uart_tx    (tx),
        .i_uart_cts_n (cts),
        .o_busy       (busy),
        .o_grant      (grant)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] sb_q[$];
    logic [7:0] rx_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Acceptance logger: predicts the round-robin winner and queues its byte.
    logic m_grant = 1'b1;
    logic exp_idx;
    always @(negedge clk) begin
        #4;
        if (rst) begin
            m_grant = 1'b1;
        end else if ((v0 && r0) || (v1 && r1)) begin
            exp_idx = (v0 && v1) ? !m_grant : v1;
            chk("arb_ready", 32'({r1, r0}), exp_idx ? 32'd2 : 32'd1);
            sb_q.push_back(exp_idx ? d1 : d0);
            m_grant = exp_idx;
        end
    end

    // Line monitor: decodes 8N1 frames sample by sample and checks shape and busy.
    logic       mon_active = 1'b0;
    int         mon_cnt = 0;
    int         idle_run = 0;
    int         last_gap = 0;
    int         frames_done = 0;
    int         idle_busy_err = 0;
    logic       shape_ok = 1'b1;
    logic [7:0] rx_byte = 8'h00;
    int         slot;
    int         phase;
    always @(negedge clk) begin
        if (rst) begin
            if (mon_active && sb_q.size() > 0) void'(sb_q.pop_front());
            mon_active = 1'b0;
            idle_run = 0;
        end else if (!mon_active) begin
            if (tx === 1'b0) begin
                mon_active = 1'b1;
                mon_cnt = 1;
                shape_ok = busy;
                last_gap = idle_run;
                idle_run = 0;
            end else begin
                idle_run++;
                if (busy !== 1'b0) idle_busy_err++;
            end
        end else begin
            slot = mon_cnt / CPB;
            phase = mon_cnt % CPB;
            if (busy !== 1'b1) shape_ok = 1'b0;
            if (slot == 0) begin
                if (tx !== 1'b0) shape_ok = 1'b0;
            end else if (slot == 9) begin
                if (tx !== 1'b1) shape_ok = 1'b0;
            end else if (phase == 0) begin
                rx_byte[3'(slot - 1)] = tx;
            end else if (tx !== rx_byte[3'(slot - 1)]) begin
                shape_ok = 1'b0;
            end
            mon_cnt++;
            if (mon_cnt == FRAME) begin
                mon_active = 1'b0;
                frames_done++;
                rx_log.push_back(rx_byte);
                chk("frame_shape", 32'(shape_ok), 32'd1);
                if (sb_q.size() == 0) chk("frame_unexpected", 32'(rx_byte), 32'hFFFF_FFFF);
                else chk("frame_data", 32'(rx_byte), 32'(sb_q.pop_front()));
            end
        end
    end

    task automatic do_reset(input logic cts_val);
        @(negedge clk);
        rst = 1'b1;
        v0 = 1'b0;
        v1 = 1'b0;
        cts = cts_val;
        #1;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'({r1, r0}), 32'd0);
        chk("rst_grant", 32'(grant), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_busy(input int budget);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < budget && !ok; k++) begin
            @(negedge clk);
            if (busy === 1'b1) ok = 1'b1;
        end
        chk("busy_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_frames(input int target, input int budget);
        logic ok;
        ok = (frames_done >= target);
        for (int k = 0; k < budget && !ok; k++) begin
            @(negedge clk);
            if (frames_done >= target) ok = 1'b1;
        end
        chk("frame_timeout", 32'(ok), 32'd1);
    endtask

    typedef struct {
        logic cts_n;
        logic val0;
        logic val1;
        logic exp_r0;
        logic exp_r1;
        logic exp_grant;
    } vec_t;

    vec_t vecs[6];
    int   base;
    int   edges;
    int   err;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{cts_n: 1'b1, val0: 1'b1, val1: 1'b0, exp_r0: 1'b0, exp_r1: 1'b0, exp_grant: 1'b1};
        vecs[1] = '{cts_n: 1'b1, val0: 1'b1, val1: 1'b1, exp_r0: 1'b0, exp_r1: 1'b0, exp_grant: 1'b1};
        vecs[2] = '{cts_n: 1'b0, val0: 1'b0, val1: 1'b0, exp_r0: 1'b0, exp_r1: 1'b0, exp_grant: 1'b1};
        vecs[3] = '{cts_n: 1'b0, val0: 1'b1, val1: 1'b0, exp_r0: 1'b1, exp_r1: 1'b0, exp_grant: 1'b1};
        vecs[4] = '{cts_n: 1'b0, val0: 1'b0, val1: 1'b1, exp_r0: 1'b0, exp_r1: 1'b1, exp_grant: 1'b1};
        vecs[5] = '{cts_n: 1'b0, val0: 1'b1, val1: 1'b1, exp_r0: 1'b1, exp_r1: 1'b0, exp_grant: 1'b1};

        // Ready table: valids are withdrawn before the edge, so nothing may be accepted.
        do_reset(1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cts = vecs[i].cts_n;
            repeat (3) @(negedge clk);
            d0 = 8'(8'h40 + i);
            d1 = 8'(8'h80 + i);
            v0 = vecs[i].val0;
            v1 = vecs[i].val1;
            #1;
            chk("tbl_ready0", 32'(r0), 32'(vecs[i].exp_r0));
            chk("tbl_ready1", 32'(r1), 32'(vecs[i].exp_r1));
            v0 = 1'b0;
            v1 = 1'b0;
            @(negedge clk);
            #1;
            chk("tbl_grant", 32'(grant), 32'(vecs[i].exp_grant));
            chk("tbl_busy", 32'(busy), 32'd0);
        end

        // Single 0xA5 frame, including synchronizer latency after reset release.
        do_reset(1'b0);
        rx_log.delete();
        d0 = 8'hA5;
        v0 = 1'b1;
        @(posedge clk);
        #1;
        chk("sync_lat_edge1", 32'(r0), 32'd0);
        @(posedge clk);
        #1;
        chk("sync_lat_edge2", 32'(r0), 32'd1);
        wait_busy(10);
        v0 = 1'b0;
        base = frames_done;
        wait_frames(base + 1, FRAME + 10);
        chk("a5_grant", 32'(grant), 32'd0);
        chk("a5_count", 32'(rx_log.size()), 32'd1);
        if (rx_log.size() > 0) chk("a5_byte", 32'(rx_log[0]), 32'hA5);

        // Continuous contention alternates 0x11, 0x22, 0x11 with one idle cycle between.
        do_reset(1'b0);
        rx_log.delete();
        d0 = 8'h11;
        d1 = 8'h22;
        v0 = 1'b1;
        v1 = 1'b1;
        base = frames_done;
        wait_frames(base + 2, 3 * FRAME);
        chk("rr_gap2", 32'(last_gap), 32'd1);
        wait_busy(10);
        v0 = 1'b0;
        v1 = 1'b0;
        wait_frames(base + 3, FRAME + 10);
        chk("rr_gap3", 32'(last_gap), 32'd1);
        chk("rr_count", 32'(rx_log.size()), 32'd3);
        if (rx_log.size() == 3) begin
            chk("rr_byte0", 32'(rx_log[0]), 32'h11);
            chk("rr_byte1", 32'(rx_log[1]), 32'h22);
            chk("rr_byte2", 32'(rx_log[2]), 32'h11);
        end

        // CTS held off blocks req1; its release opens ready two edges later.
        do_reset(1'b1);
        rx_log.delete();
        d1 = 8'h5A;
        v1 = 1'b1;
        err = 0;
        repeat (10) begin
            @(negedge clk);
            if (r1 !== 1'b0 || r0 !== 1'b0 || tx !== 1'b1) err++;
        end
        chk("cts_hold", 32'(err), 32'd0);
        @(negedge clk);
        cts = 1'b0;
        edges = 0;
        for (int k = 1; k <= 6 && edges == 0; k++) begin
            @(posedge clk);
            #1;
            if (r1 === 1'b1) edges = k;
        end
        chk("cts_ready_lat", 32'(edges), 32'd2);
        wait_busy(10);
        v1 = 1'b0;
        base = frames_done;
        wait_frames(base + 1, FRAME + 10);
        chk("cts_grant", 32'(grant), 32'd1);
        if (rx_log.size() > 0) chk("cts_byte", 32'(rx_log[0]), 32'h5A);

        // CTS raised mid-frame: frame completes, next byte waits for CTS.
        do_reset(1'b0);
        rx_log.delete();
        d0 = 8'h3C;
        v0 = 1'b1;
        wait_busy(10);
        v0 = 1'b0;
        base = frames_done;
        repeat (12) @(negedge clk);
        cts = 1'b1;
        d0 = 8'h77;
        v0 = 1'b1;
        wait_frames(base + 1, FRAME + 10);
        err = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy !== 1'b0 || r0 !== 1'b0) err++;
        end
        chk("cts_mid_block", 32'(err), 32'd0);
        cts = 1'b0;
        wait_busy(10);
        v0 = 1'b0;
        wait_frames(base + 2, FRAME + 10);
        chk("cts_mid_count", 32'(rx_log.size()), 32'd2);
        if (rx_log.size() == 2) begin
            chk("cts_mid_byte0", 32'(rx_log[0]), 32'h3C);
            chk("cts_mid_byte1", 32'(rx_log[1]), 32'h77);
        end

        // Reset during data bit 3 aborts instantly; req0 then wins first contention.
        do_reset(1'b0);
        d0 = 8'hC3;
        v0 = 1'b1;
        wait_busy(10);
        v0 = 1'b0;
        repeat (17) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_tx", 32'(tx), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rx_log.delete();
        d0 = 8'h11;
        d1 = 8'h22;
        v0 = 1'b1;
        v1 = 1'b1;
        rst = 1'b0;
        wait_busy(10);
        v0 = 1'b0;
        v1 = 1'b0;
        base = frames_done;
        wait_frames(base + 1, FRAME + 10);
        repeat (5) @(negedge clk);
        chk("abort_count", 32'(rx_log.size()), 32'd1);
        if (rx_log.size() > 0) chk("abort_first", 32'(rx_log[0]), 32'h11);
        chk("abort_grant", 32'(grant), 32'd0);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        chk("idle_busy", 32'(idle_busy_err), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter: ClksPerBit, default 868, i_clk cycles per UART bit (115200 baud at 100 MHz); legal range >= 2.
REQ-002 i_clk  input  1  sole clock; all state on rising edge.
REQ-003 i_rst  input  1  reset, asynchronous, active-high.
REQ-004 i_req0_data  input  8  requester 0 byte.
REQ-005 i_req0_valid  input  1  requester 0 has a byte.
REQ-006 o_req0_ready  output  1  requester 0 byte accepted this cycle when valid&ready.
REQ-007 i_req1_data  input  8  requester 1 byte.
REQ-008 i_req1_valid  input  1  requester 1 has a byte.
REQ-009 o_req1_ready  output  1  requester 1 byte accepted this cycle when valid&ready.
REQ-010 o_uart_tx  output  1  serial 8N1 line, idle high.
REQ-011 i_uart_cts_n  input  1  clear-to-send, active-low, asynchronous to i_clk.
REQ-012 o_busy  output  1  high while a frame is on the line.
REQ-013 o_grant  output  1  index of the requester most recently accepted.

Function
REQ-014 The block SHALL pass i_uart_cts_n through a 2-flop synchronizer (reset value 1, i.e. not clear) and use only the synchronized value.
REQ-015 The FSM SHALL have states IDLE, START, DATA, STOP; reset state IDLE.
REQ-016 In IDLE with synchronized CTS low and at least one valid, exactly one ready SHALL be asserted combinationally; all readys SHALL be low in every other case.
REQ-017 Arbitration SHALL be round-robin: a single valid requester is granted; if both valid, the requester other than o_grant is granted.
REQ-018 On acceptance the byte SHALL be latched into a shift register, o_grant updated to the granted index, and the FSM SHALL move to START on the next edge.
REQ-019 START SHALL drive o_uart_tx=0 for exactly ClksPerBit cycles, then go to DATA.
REQ-020 DATA SHALL drive 8 bits LSB-first, each for exactly ClksPerBit cycles, using a 3-bit bit counter; after bit 7 go to STOP.
REQ-021 STOP SHALL drive o_uart_tx=1 for exactly ClksPerBit cycles, then go to IDLE.
REQ-022 A frame SHALL last exactly 10*ClksPerBit cycles; the next acceptance SHALL occur no earlier than the first IDLE cycle after STOP (minimum 1 idle cycle between frames).
REQ-023 The baud counter SHALL be $clog2(ClksPerBit) bits wide, count 0..ClksPerBit-1, and wrap to 0 at each bit boundary.
REQ-024 CTS SHALL be evaluated only in IDLE; CTS deasserting mid-frame SHALL NOT abort or stretch the current frame.
REQ-025 o_busy SHALL be high in START, DATA, STOP and low in IDLE.
REQ-026 A valid deasserted before acceptance SHALL be dropped from arbitration without any side effect.

Reset
REQ-027 On i_rst high, asynchronously: FSM=IDLE, o_uart_tx=1, o_busy=0, both readys=0, o_grant=1 (requester 0 wins first contention), counters=0, shift register=0, synchronizer=1.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately, with the line returning high; the aborted byte SHALL NOT be retransmitted.
REQ-029 After reset release, the first acceptance SHALL be no earlier than the third rising edge (synchronizer latency).

Verification (ClksPerBit=4)
REQ-030 Req0 sends 0xA5, CTS low -> o_uart_tx = 0,1,0,1,0,0,1,0,1,1, each level for 4 cycles; o_busy high for 40 cycles; o_grant=0.
REQ-031 Both valid continuously (req0=0x11, req1=0x22), CTS low -> frames 0x11, 0x22, 0x11 in that order, each 40 cycles, separated by 1 idle cycle.
REQ-032 CTS held high with req1 valid -> readys stay low and the line stays high; CTS drops at cycle N -> o_req1_ready asserts at cycle N+2.
REQ-033 CTS raised during DATA of frame 0x3C -> frame completes unchanged; no further acceptance until CTS is low again.
REQ-034 i_rst pulsed during DATA bit 3 -> o_uart_tx=1 and o_busy=0 in the same cycle; with both valid afterwards, req0 is granted first.
REQ-035 Req0 valid for 1 cycle while CTS is high, then dropped -> no frame is sent and o_grant is unchanged.
